// File: rtl/instrumented_adder_ctrl_if.sv
// Control/status and adder-side bus of the instrumented adder measurement sequencer.
interface instrumented_adder_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32,
  parameter int WIN_W = 16
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIN_W-1:0] window_len;
  logic             chain_out;
  logic [WIDTH-1:0] s_output;
  logic [WIDTH-1:0] a_input;
  logic [WIDTH-1:0] b_input;
  logic             ring_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             sum_err;

  modport master (
    output start, abort, a_in, b_in, window_len, chain_out, s_output,
    input  a_input, b_input, ring_en, busy, done, count, overflow, sum_err
  );

  modport slave (
    input  start, abort, a_in, b_in, window_len, chain_out, s_output,
    output a_input, b_input, ring_en, busy, done, count, overflow, sum_err
  );
endinterface

// File: rtl/instrumented_adder_ctrl.sv
// Measurement sequencer for the instrumented Sklansky adder: load, settle, gated ring window, edge count.
// Optional settled-sum check is enabled by defining IADDER_CTRL_SUM_CHECK_EN.
module instrumented_adder_ctrl #(
  parameter int WIDTH         = 32,
  parameter int CNT_W         = 32,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input logic                      wb_clk_i,
  input logic                      wb_rst_i,
  instrumented_adder_ctrl_if.slave bus
);
  localparam int PH_MAX = SETTLE_CYCLES + SYNC_STAGES + 1;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TMR_W  = (WIN_W > PH_W) ? WIN_W : PH_W;
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic             accept;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIN_W-1:0] win;
  logic [SYNC_STAGES-1:0] sync;
  logic             sync_d;
  logic             rise;
  logic             counting;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             ring_q, busy_q, done_q;

  // Saturating increment: MSB of the result flags a blocked increment.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return {1'b1, c};
    return {1'b0, c + CNT_W'(1)};
  endfunction

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    accept    = 1'b0;
    if (tmr != '0) tmr_nxt = tmr - TMR_ONE;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_nxt = S_LOAD;
          accept    = 1'b1;
        end
      end
      S_LOAD: begin
        state_nxt = S_SETTLE;
        tmr_nxt   = TMR_W'(SETTLE_CYCLES - 1);
      end
      S_SETTLE: begin
        if (tmr == '0) begin
          if (win == '0) begin
            state_nxt = S_DRAIN;
            tmr_nxt   = TMR_W'(SYNC_STAGES);
          end else begin
            state_nxt = S_RUN;
            tmr_nxt   = TMR_W'(win) - TMR_ONE;
          end
        end
      end
      S_RUN: begin
        if (tmr == '0) begin
          state_nxt = S_DRAIN;
          tmr_nxt   = TMR_W'(SYNC_STAGES);
        end
      end
      S_DRAIN: begin
        if (tmr == '0) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort wins over everything, including a simultaneous start.
    if (bus.abort) begin
      state_nxt = S_IDLE;
      accept    = 1'b0;
    end
  end

  // Outputs registered from next state so ring_en cannot glitch on state decode.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ring_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ring_q <= (state_nxt == S_RUN);
      busy_q <= (state_nxt == S_LOAD) || (state_nxt == S_SETTLE) ||
                (state_nxt == S_RUN)  || (state_nxt == S_DRAIN);
      done_q <= (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      a_q <= '0;
      b_q <= '0;
      win <= '0;
    end else if (accept) begin
      a_q <= bus.a_in;
      b_q <= bus.b_in;
      win <= bus.window_len;
    end
  end

  // chain_out synchroniser plus one edge-detect flop
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync   <= '0;
      sync_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], bus.chain_out};
      sync_d <= sync[SYNC_STAGES-1];
    end
  end

  assign rise     = sync[SYNC_STAGES-1] & ~sync_d;
  assign counting = (state == S_RUN) || (state == S_DRAIN);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || bus.abort || accept) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (counting && rise) begin
      cnt <= sat_inc(cnt)[CNT_W-1:0];
      if (sat_inc(cnt)[CNT_W]) ovf <= 1'b1;
    end
  end

`ifdef IADDER_CTRL_SUM_CHECK_EN
  logic             sum_err_q;
  logic [WIDTH-1:0] sum_exp;

  assign sum_exp = a_q + b_q;

  // Adder has settled by the last SETTLE cycle; compare once there.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || bus.abort || accept) begin
      sum_err_q <= 1'b0;
    end else if ((state == S_SETTLE) && (tmr == '0) && (bus.s_output != sum_exp)) begin
      sum_err_q <= 1'b1;
    end
  end

  assign bus.sum_err = sum_err_q;
`else
  logic unused_s_output;
  assign unused_s_output = ^bus.s_output;
  assign bus.sum_err     = 1'b0;
`endif

  assign bus.a_input  = a_q;
  assign bus.b_input  = b_q;
  assign bus.ring_en  = ring_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = cnt;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_instrumented_adder_ctrl.sv
// Self-checking bench for instrumented_adder_ctrl: directed table, corner sequences, randomized runs.
module tb_instrumented_adder_ctrl;
  localparam int SET = 4;
  localparam int SYN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instrumented_adder_ctrl_if ifa ();
  instrumented_adder_ctrl_if #(.CNT_W(4)) ifs ();

  instrumented_adder_ctrl dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(ifa));
  instrumented_adder_ctrl #(.CNT_W(4)) dut_s (.wb_clk_i(clk), .wb_rst_i(rst), .bus(ifs));

  // The narrow-counter instance sees exactly the same stimulus.
  assign ifs.start      = ifa.start;
  assign ifs.abort      = ifa.abort;
  assign ifs.a_in       = ifa.a_in;
  assign ifs.b_in       = ifa.b_in;
  assign ifs.window_len = ifa.window_len;
  assign ifs.chain_out  = ifa.chain_out;
  assign ifs.s_output   = ifa.s_output;

  int checks = 0;
  int errors = 0;

  // chain_out as seen at each rising clock edge, indexed by edge number
  logic hist [0:16383];
  int   cyc = 0;
  always @(posedge clk) begin
    hist[cyc % 16384] <= ifa.chain_out;
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Rising edges of chain_out that reach the counter while the sequencer is in RUN or DRAIN.
  // Phase t (cycles after the accepting edge e0) is RUN/DRAIN for t in [SET+1, SET+w+SYN+1];
  // the edge visible at the synchroniser output during phase t was sampled SYN-1 edges earlier.
  function automatic int model_count(input int e0, input int w);
    int n = 0;
    for (int t = SET + 1; t <= SET + w + SYN + 1; t++)
      if (hist[(e0 + t - SYN + 1) % 16384] && !hist[(e0 + t - SYN) % 16384]) n++;
    return n;
  endfunction

  function automatic logic exp_sum_err(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
`ifdef IADDER_CTRL_SUM_CHECK_EN
    return (s != a + b);
`else
    return 1'b0;
`endif
  endfunction

  // mode 0: random chain_out every cycle; mode 1: chain_out toggles each cycle while ring_en is high
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [15:0] w,
                     input int mode, input logic [31:0] s, input bit ig_start, output int got);
    int e0, t, ring_cycles, done_t, model, exp_done;
    @(negedge clk);
    ifa.a_in = a; ifa.b_in = b; ifa.window_len = w; ifa.s_output = s; ifa.start = 1'b1;
    e0 = cyc;
    @(negedge clk);
    ifa.start = 1'b0;
    t = 0; ring_cycles = 0; done_t = -1;
    exp_done = SET + int'(w) + SYN + 2;
    chk("busy_after_start", ifa.busy, 1);
    while (t < exp_done + 20) begin
      if (ifa.ring_en) ring_cycles++;
      if (ifa.done) begin
        done_t = t;
        break;
      end
      if (t == 3) chk("ignored_start_a", ifa.a_input, a);
      if (t == 2 && ig_start) begin
        ifa.start = 1'b1;
        ifa.a_in  = ~a;
      end else begin
        ifa.start = 1'b0;
      end
      if (mode == 0) ifa.chain_out = 1'($urandom_range(0, 1));
      else if (ifa.ring_en) ifa.chain_out = ~ifa.chain_out;
      @(negedge clk);
      t++;
    end
    ifa.start = 1'b0;
    model = model_count(e0, int'(w));
    chk("done_latency", done_t, exp_done);
    chk("ring_cycles", ring_cycles, w);
    chk("count", ifa.count, model);
    chk("overflow", ifa.overflow, 0);
    chk("a_input", ifa.a_input, a);
    chk("b_input", ifa.b_input, b);
    chk("busy_in_done", ifa.busy, 0);
    chk("sum_err", ifa.sum_err, exp_sum_err(a, b, s));
    chk("small_count", ifs.count, (model > 15) ? 15 : model);
    chk("small_overflow", ifs.overflow, (model > 15) ? 1 : 0);
    got = model;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] w;
    int          mode;
    logic [31:0] s;
    int          cmin;
    int          cmax;
    bit          small_sat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int got;
    int t;
    ifa.start = 1'b0; ifa.abort = 1'b0; ifa.a_in = '0; ifa.b_in = '0;
    ifa.window_len = '0; ifa.chain_out = 1'b0; ifa.s_output = '0;

    tbl[0] = '{32'h80,       32'h0, 16'd10, 1, 32'h80, 4, 6, 1'b0};
    tbl[1] = '{32'h5,        32'h7, 16'd0,  1, 32'hC,  0, 0, 1'b0};
    tbl[2] = '{32'h1,        32'h2, 16'd64, 1, 32'h3, 30, 34, 1'b1};
    tbl[3] = '{32'hFFFFFFFF, 32'h1, 16'd1,  0, 32'h0,  0, 2, 1'b0};
    tbl[4] = '{32'h5,        32'h7, 16'd3,  1, 32'hB,  0, 3, 1'b0};
    tbl[5] = '{32'h5,        32'h7, 16'd3,  1, 32'hC,  0, 3, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_ring_en", ifa.ring_en, 0);
    chk("rst_count", ifa.count, 0);
    chk("rst_a_input", ifa.a_input, 0);
    chk("rst_overflow", ifa.overflow, 0);
    chk("rst_sum_err", ifa.sum_err, 0);

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].a, tbl[i].b, tbl[i].w, tbl[i].mode, tbl[i].s, 1'b0, got);
      checks++;
      if (int'(ifa.count) < tbl[i].cmin || int'(ifa.count) > tbl[i].cmax) begin
        errors++;
        $display("FAIL table_count_range[%0d]: got %0d expected %0d..%0d", i, ifa.count, tbl[i].cmin, tbl[i].cmax);
      end
      if (tbl[i].small_sat) begin
        chk("sat_count_4b", ifs.count, 4'hF);
        chk("sat_overflow_4b", ifs.overflow, 1);
      end
    end

    // Abort three cycles into RUN, after an ignored start during SETTLE.
    @(negedge clk);
    ifa.a_in = 32'hA5A5; ifa.b_in = 32'h1; ifa.window_len = 16'd20; ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    for (t = 0; t < 8; t++) begin
      if (t == 2) begin ifa.start = 1'b1; ifa.a_in = 32'h1234; end
      else ifa.start = 1'b0;
      if (t == SET + 1 + 2) ifa.abort = 1'b1;
      if (ifa.ring_en) ifa.chain_out = ~ifa.chain_out;
      @(negedge clk);
    end
    ifa.abort = 1'b0;
    chk("abort_ring_en", ifa.ring_en, 0);
    chk("abort_busy", ifa.busy, 0);
    chk("abort_done", ifa.done, 0);
    chk("abort_count", ifa.count, 0);
    chk("abort_a_input", ifa.a_input, 32'hA5A5);
    repeat (5) @(negedge clk);
    chk("abort_stays_idle", ifa.busy, 0);

    // abort and start in the same cycle: abort wins
    ifa.start = 1'b1; ifa.abort = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ifa.abort = 1'b0;
    chk("abort_beats_start", ifa.busy, 0);

    // Reset in the middle of RUN
    @(negedge clk);
    ifa.a_in = 32'h77; ifa.b_in = 32'h1; ifa.window_len = 16'd100; ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    for (t = 0; t < 50; t++) begin
      if (ifa.ring_en) ifa.chain_out = ~ifa.chain_out;
      @(negedge clk);
    end
    chk("pre_reset_ring_en", ifa.ring_en, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ring_en", ifa.ring_en, 0);
    chk("mid_rst_busy", ifa.busy, 0);
    chk("mid_rst_count", ifa.count, 0);
    chk("mid_rst_a_input", ifa.a_input, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized runs against the windowed edge-count model
    for (int r = 0; r < 25; r++) begin
      logic [31:0] ra, rb, rs;
      ra = $urandom; rb = $urandom;
      rs = ra + rb;
      if ($urandom_range(0, 3) == 0) rs = rs ^ 32'h1;
      run(ra, rb, 16'($urandom_range(0, 24)), int'($urandom_range(0, 1)), rs,
          1'($urandom_range(0, 1)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
